// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - memory-game sequence playback: ROM positions 0..limite shown on LEDs
module exibe_sequencia #(
    parameter int T_ON  = 25_000_000,
    parameter int T_OFF = 12_500_000,
    parameter int TW    = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] mem_dado,
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        ACENDE  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FINAL   = 4'hF
    } estado_t;

    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    estado_t       state_q, state_d;
    logic [3:0]    addr_q, addr_d;
    logic [3:0]    lim_q, lim_d;
    logic [3:0]    leds_q, leds_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;

    // Address and limit are updated on the edge entering a state, so the
    // combinational ROM already shows the right value when ACENDE is entered.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lim_d   = lim_q;
        timer_d = timer_q;
        case (state_q)
            INICIAL, FINAL: begin
                if (iniciar) begin
                    state_d = PREPARA;
                    addr_d  = 4'd0;
                    timer_d = '0;
                    lim_d   = limite;
                end
            end
            PREPARA: begin
                state_d = ACENDE;
                timer_d = '0;
            end
            ACENDE: begin
                if (timer_q == ON_LAST) begin
                    state_d = APAGA;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            APAGA: begin
                if (timer_q == OFF_LAST) begin
                    timer_d = '0;
                    if (addr_q == lim_q) begin
                        state_d = FINAL;
                    end else begin
                        state_d = PROXIMO;
                        addr_d  = addr_q + 4'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            PROXIMO: begin
                state_d = ACENDE;
                timer_d = '0;
            end
            default: begin
                state_d = INICIAL;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        leds_d    = 4'd0;
        ocupado_d = 1'b0;
        pronto_d  = 1'b0;
        if (state_d == ACENDE) begin
            leds_d = (state_q == ACENDE) ? leds_q : mem_dado;
        end
        case (state_d)
            PREPARA, ACENDE, APAGA, PROXIMO: ocupado_d = 1'b1;
            FINAL:                           pronto_d  = 1'b1;
            default:                         ocupado_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= INICIAL;
            addr_q    <= 4'd0;
            lim_q     <= 4'd0;
            leds_q    <= 4'd0;
            timer_q   <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lim_q     <= lim_d;
            leds_q    <= leds_d;
            timer_q   <= timer_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign mem_endereco = addr_q;
    assign leds         = leds_q;
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;
    assign db_estado    = state_q;

endmodule

// File: doc/exibe_sequencia.md
# exibe_sequencia

Playback controller for the memory game: on `iniciar`, reads the stored sequence from the game ROM, positions 0 through `limite`, and shows each 4-bit value on the LEDs for a fixed on-time followed by a blank gap. It is the output side of the game interface. The existing datapath and control unit read the player's `chaves` and compare them against the ROM. This block drives the same ROM to present the sequence to the player before input starts. `pronto` tells the top-level FSM that playback has finished.

## Interface
Parameters:
- `T_ON`, default 25_000_000: clock cycles each value stays lit (0.5 s at 50 MHz).
- `T_OFF`, default 12_500_000: clock cycles of blank gap after each value.
- `TW`, default 25: timer width; must satisfy 2^TW > max(T_ON, T_OFF).

Ports:
- `clock`, in, 1: system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset (reset asserted when 0).
- `iniciar`, in, 1: start request, level-sampled.
- `limite`, in, 4: index of the last position to show (0..15).
- `mem_dado`, in, 4: ROM data; combinational read of `mem_endereco`.
- `mem_endereco`, out, 4: ROM address (registered position counter).
- `leds`, out, 4: displayed value (registered).
- `ocupado`, out, 1: high while playback is in progress.
- `pronto`, out, 1: high in FINAL.
- `db_estado`, out, 4: current state code, for the 7-segment debug display.

## Operation
- States and codes:
  - INICIAL = 0
  - PREPARA = 1
  - ACENDE = 2
  - APAGA = 3
  - PROXIMO = 4
  - FINAL = F
- Unused codes go to INICIAL.
- INICIAL or FINAL, with `iniciar`=1 → PREPARA. Otherwise the state holds.
- PREPARA (1 cycle):
  - `mem_endereco` ← 0, timer ← 0.
  - `limite` captured into an internal register; later changes to `limite` are ignored until the next start.
  - → ACENDE.
- ACENDE (T_ON cycles):
  - On the edge entering ACENDE, `leds` ← `mem_dado`.
  - The timer counts 0..T_ON-1; at T_ON-1 → APAGA, timer ← 0.
- APAGA (T_OFF cycles):
  - On the edge entering APAGA, `leds` ← 0.
  - At T_OFF-1: if `mem_endereco` == captured `limite` → FINAL, otherwise → PROXIMO.
- PROXIMO (1 cycle): `mem_endereco` ← `mem_endereco`+1, timer ← 0, → ACENDE.
- FINAL:
  - `pronto`=1, `leds`=0; `mem_endereco` holds the last address shown.
  - Waits for `iniciar`.
- `ocupado`=1 in PREPARA, ACENDE, APAGA and PROXIMO; 0 in INICIAL and FINAL.
- `iniciar` is ignored while `ocupado`=1; there is no restart mid-playback.
- Boundary conditions:
  - `limite`=0: exactly one value is shown.
  - `limite`=15: all 16 values are shown. The counter never wraps, because the compare at 15 exits before any increment.

## Timing
- Reset values (async, `reset`=0): state INICIAL, `mem_endereco`=0, `leds`=0, timer=0, `ocupado`=0, `pronto`=0, `db_estado`=0.
- Deasserting `reset` mid-playback: the block resumes from INICIAL, and `leds` clear immediately when reset asserts.
- `iniciar` sampled high at edge k: state PREPARA after edge k; first `leds` value visible after edge k+1.
- For captured `limite` = L, the time from the edge entering PREPARA to the edge entering FINAL is 1 + (L+1)·(T_ON+T_OFF) + L cycles.
- `leds` are nonzero for exactly T_ON cycles per position and zero for exactly T_OFF cycles between positions.
- `pronto` rises on the same edge that clears `ocupado`.
- With `iniciar` held high in FINAL, a new playback starts on the next edge.
- All outputs are registered, except `db_estado`, which is a direct decode of the state register.

## Test plan
Bench overrides: T_ON=4, T_OFF=2. ROM contents for positions 0..15 are 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex nibbles).

1. Reset for 1 cycle, `iniciar`=0 for 5 cycles → state 0; `leds`=0, `pronto`=0, `ocupado`=0 throughout.
2. `limite`=3, 1-cycle `iniciar` pulse → `leds` shows 0001, 0010, 0100, 1000, each for 4 cycles, with 2 cycles of 0000 after each. `pronto`=1 exactly 1+4·6+3 = 28 cycles after entering PREPARA; `mem_endereco`=3.
3. `limite`=0 → only 0001 is shown, for 4 cycles; FINAL after 7 cycles.
4. `limite`=15 → all 16 values are shown in order; final `mem_endereco`=15 (no wrap); FINAL after 1+16·6+15 = 112 cycles.
5. During scenario 2, pulse `iniciar` again and change `limite` to 7 → both are ignored; the playback is identical to scenario 2. Then `iniciar` in FINAL → a new playback of 8 values (since `limite`=7), with `pronto` dropping 1 cycle after the `iniciar` edge.
6. Assert `reset`=0 asynchronously mid-ACENDE at position 2 → `leds`=0 and `db_estado`=0 immediately, before the next clock edge; after release, state stays INICIAL until `iniciar`.
